// File: rtl/sram_arb_pkg.sv
// Shared types, widths and port indices for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WDATA_W = 32;
    localparam int unsigned RDATA_W = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } arb_state_e;

    localparam logic PORT_CACHE = 1'b0;
    localparam logic PORT_AUX   = 1'b1;

endpackage

// File: rtl/sram_arb_if.sv
// Request/response bus used on both requester ports and on the SRAM controller side.
interface sram_arb_if;
    import sram_arb_pkg::*;

    logic               read_en;
    logic               write_en;
    logic [ADDR_W-1:0]  address;
    logic [WDATA_W-1:0] write_data;
    logic [RDATA_W-1:0] rdata;
    logic               ready;

    modport master (
        output read_en, write_en, address, write_data,
        input  rdata, ready
    );

    modport slave (
        input  read_en, write_en, address, write_data,
        output rdata, ready
    );
endinterface

// File: rtl/sram_arb_picker.sv
// Two-way winner selection. SRAM_ARB_RR_EN selects round-robin on `last`,
// otherwise port 0 has fixed priority.
module sram_arb_picker
    import sram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
`ifdef SRAM_ARB_RR_EN
    input  logic last_i,
`endif
    output logic grant_o
);

    always_comb begin
        grant_o = PORT_CACHE;
        if (req0_i && req1_i) begin
`ifdef SRAM_ARB_RR_EN
            grant_o = ~last_i;
`else
            grant_o = PORT_CACHE;
`endif
        end else if (req1_i) begin
            grant_o = PORT_AUX;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between the cache port (m0) and an auxiliary port (m1).
// Define SRAM_ARB_RR_EN for round-robin; default build is fixed priority to port 0.
module sram_arbiter
    import sram_arb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    sram_arb_if.slave  m0_io,
    sram_arb_if.slave  m1_io,
    sram_arb_if.master sram_io
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       req0, req1, winner;
`ifdef SRAM_ARB_RR_EN
    logic       last_q, last_d;
`endif

    assign req0 = m0_io.read_en | m0_io.write_en;
    assign req1 = m1_io.read_en | m1_io.write_en;

    sram_arb_picker u_picker (
        .req0_i  (req0),
        .req1_i  (req1),
`ifdef SRAM_ARB_RR_EN
        .last_i  (last_q),
`endif
        .grant_o (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= PORT_CACHE;
`ifdef SRAM_ARB_RR_EN
            last_q  <= PORT_AUX;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
`ifdef SRAM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
`ifdef SRAM_ARB_RR_EN
        last_d             = last_q;
`endif
        sram_io.read_en    = 1'b0;
        sram_io.write_en   = 1'b0;
        sram_io.address    = '0;
        sram_io.write_data = '0;
        m0_io.ready        = 1'b0;
        m0_io.rdata        = '0;
        m1_io.ready        = 1'b0;
        m1_io.rdata        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d = winner;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Both strobes high on one port is treated as a write.
                if (grant_q == PORT_AUX) begin
                    sram_io.write_en   = m1_io.write_en;
                    sram_io.read_en    = m1_io.read_en & ~m1_io.write_en;
                    sram_io.address    = m1_io.address;
                    sram_io.write_data = m1_io.write_data;
                end else begin
                    sram_io.write_en   = m0_io.write_en;
                    sram_io.read_en    = m0_io.read_en & ~m0_io.write_en;
                    sram_io.address    = m0_io.address;
                    sram_io.write_data = m0_io.write_data;
                end
                if (sram_io.ready) begin
                    if (grant_q == PORT_AUX) begin
                        m1_io.ready = 1'b1;
                        m1_io.rdata = sram_io.rdata;
                    end else begin
                        m0_io.ready = 1'b1;
                        m0_io.rdata = sram_io.rdata;
                    end
`ifdef SRAM_ARB_RR_EN
                    last_d  = grant_q;
`endif
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter; expectations follow the build's arbitration mode.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    sram_arb_if m0_bus ();
    sram_arb_if m1_bus ();
    sram_arb_if sram_bus ();

    sram_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .m0_io   (m0_bus),
        .m1_io   (m1_bus),
        .sram_io (sram_bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_bus.read_en = 0; m0_bus.write_en = 0; m0_bus.address = '0; m0_bus.write_data = '0;
        m1_bus.read_en = 0; m1_bus.write_en = 0; m1_bus.address = '0; m1_bus.write_data = '0;
        sram_bus.ready = 0; sram_bus.rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({sram_bus.read_en, sram_bus.write_en, m0_bus.ready, m1_bus.ready} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {sram_bus.read_en, sram_bus.write_en, m0_bus.ready, m1_bus.ready});
        end
        checks++;
        if (sram_bus.address !== '0 || m0_bus.rdata !== '0 || m1_bus.rdata !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%h r0=%h r1=%h exp=0",
                     sram_bus.address, m0_bus.rdata, m1_bus.rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_bus.read_en = 1; m0_bus.address = 32'h0000_0100;
        step();
        checks++;
        if (sram_bus.address !== 32'h0000_0100 || sram_bus.write_en !== 1'b0) begin
            failures++;
            $display("FAIL p0_read_addr got=%h we=%b exp=00000100 we=0",
                     sram_bus.address, sram_bus.write_en);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                sram_bus.ready = 1; sram_bus.rdata = 64'hDEAD_BEEF_0123_4567;
            end
            #1;
            checks++;
            if (sram_bus.read_en !== 1'b1) begin
                failures++;
                $display("FAIL p0_read_en cyc=%0d got=%b exp=1", i, sram_bus.read_en);
            end
            checks++;
            if (m0_bus.ready !== (i == 3) || m1_bus.ready !== 1'b0) begin
                failures++;
                $display("FAIL p0_ready cyc=%0d got m0=%b m1=%b exp m0=%b m1=0",
                         i, m0_bus.ready, m1_bus.ready, (i == 3));
            end
            if (i != 3) step();
        end
        checks++;
        if (m0_bus.rdata !== 64'hDEAD_BEEF_0123_4567 || m1_bus.rdata !== '0) begin
            failures++;
            $display("FAIL p0_rdata got=%h m1=%h exp=deadbeef01234567 m1=0",
                     m0_bus.rdata, m1_bus.rdata);
        end
        step();
        sram_bus.ready = 0; m0_bus.read_en = 0;
        #1;
        checks++;
        if (sram_bus.read_en !== 1'b0 || m0_bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL p0_release got re=%b rdy=%b exp=0 0", sram_bus.read_en, m0_bus.ready);
        end
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        m0_bus.read_en = 1; m0_bus.address = 32'h180;
        m1_bus.write_en = 1; m1_bus.address = 32'h200; m1_bus.write_data = 32'h55;
        step();
        checks++;
        if (sram_bus.address !== 32'h180 || sram_bus.read_en !== 1'b1) begin
            failures++;
            $display("FAIL sim_first got addr=%h re=%b exp=180 re=1",
                     sram_bus.address, sram_bus.read_en);
        end
        sram_bus.ready = 1; sram_bus.rdata = 64'h1111;
        #1;
        checks++;
        if (m0_bus.ready !== 1'b1 || m1_bus.ready !== 1'b0 || m1_bus.rdata !== '0) begin
            failures++;
            $display("FAIL sim_ready0 got m0=%b m1=%b r1=%h exp 1 0 0",
                     m0_bus.ready, m1_bus.ready, m1_bus.rdata);
        end
        step();
        sram_bus.ready = 0; m0_bus.read_en = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (sram_bus.read_en !== 1'b0 || sram_bus.write_en !== 1'b0) begin
                failures++;
                $display("FAIL sim_gap cyc=%0d got re=%b we=%b exp=0 0",
                         i, sram_bus.read_en, sram_bus.write_en);
            end
            step();
        end
        checks++;
        if (sram_bus.write_en !== 1'b1 || sram_bus.address !== 32'h200 ||
            sram_bus.write_data !== 32'h55) begin
            failures++;
            $display("FAIL sim_second got we=%b addr=%h wd=%h exp 1 200 55",
                     sram_bus.write_en, sram_bus.address, sram_bus.write_data);
        end
        sram_bus.ready = 1;
        #1;
        checks++;
        if (m1_bus.ready !== 1'b1 || m0_bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL sim_ready1 got m1=%b m0=%b exp 1 0", m1_bus.ready, m0_bus.ready);
        end
        step();
        sram_bus.ready = 0; m1_bus.write_en = 0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr [4];
`ifdef SRAM_ARB_RR_EN
        exp_addr = '{32'h400, 32'h500, 32'h400, 32'h500};
`else
        exp_addr = '{32'h400, 32'h400, 32'h400, 32'h400};
`endif
        do_reset();
        m0_bus.read_en = 1; m0_bus.address = 32'h400;
        m1_bus.read_en = 1; m1_bus.address = 32'h500;
        for (int t = 0; t < 4; t++) begin
            step();
            checks++;
            if (sram_bus.address !== exp_addr[t]) begin
                failures++;
                $display("FAIL b2b_grant txn=%0d got=%h exp=%h", t, sram_bus.address, exp_addr[t]);
            end
            sram_bus.ready = 1;
            #1;
            checks++;
            if (m0_bus.ready !== (exp_addr[t] == 32'h400) ||
                m1_bus.ready !== (exp_addr[t] == 32'h500)) begin
                failures++;
                $display("FAIL b2b_ready txn=%0d got m0=%b m1=%b", t, m0_bus.ready, m1_bus.ready);
            end
            step();
            sram_bus.ready = 0;
            step();
        end
        m0_bus.read_en = 0; m1_bus.read_en = 0;
        step();
    endtask

    task automatic test_read_write_both();
        do_reset();
        m0_bus.read_en = 1; m0_bus.write_en = 1;
        m0_bus.address = 32'h300; m0_bus.write_data = 32'hA5;
        step();
        checks++;
        if (sram_bus.write_en !== 1'b1 || sram_bus.read_en !== 1'b0 ||
            sram_bus.address !== 32'h300) begin
            failures++;
            $display("FAIL rw_both got we=%b re=%b addr=%h exp 1 0 300",
                     sram_bus.write_en, sram_bus.read_en, sram_bus.address);
        end
        sram_bus.ready = 1;
        step();
        sram_bus.ready = 0; m0_bus.read_en = 0; m0_bus.write_en = 0;
        step();
    endtask

    task automatic test_reset_busy();
        do_reset();
        m0_bus.read_en = 1; m0_bus.address = 32'h680;
        step();
        checks++;
        if (sram_bus.read_en !== 1'b1) begin
            failures++;
            $display("FAIL rbusy_pre got re=%b exp=1", sram_bus.read_en);
        end
        rst = 1;
        step();
        rst = 0; m0_bus.read_en = 0;
        #1;
        checks++;
        if ({sram_bus.read_en, sram_bus.write_en, m0_bus.ready, m1_bus.ready} !== 4'b0 ||
            sram_bus.address !== '0) begin
            failures++;
            $display("FAIL rbusy_idle got=%b addr=%h exp=0000 0",
                     {sram_bus.read_en, sram_bus.write_en, m0_bus.ready, m1_bus.ready},
                     sram_bus.address);
        end
        m1_bus.read_en = 1; m1_bus.address = 32'h700;
        step();
        checks++;
        if (sram_bus.read_en !== 1'b1 || sram_bus.address !== 32'h700) begin
            failures++;
            $display("FAIL rbusy_p1 got re=%b addr=%h exp 1 700", sram_bus.read_en, sram_bus.address);
        end
        sram_bus.ready = 1;
        #1;
        checks++;
        if (m1_bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL rbusy_p1_ready got=%b exp=1", m1_bus.ready);
        end
        step();
        sram_bus.ready = 0; m1_bus.read_en = 0;
        step();
    endtask

    task automatic test_spurious_ready();
        do_reset();
        sram_bus.ready = 1; sram_bus.rdata = 64'hFFFF;
        #1;
        checks++;
        if (m0_bus.ready !== 1'b0 || m1_bus.ready !== 1'b0 || m0_bus.rdata !== '0) begin
            failures++;
            $display("FAIL spur_ready got m0=%b m1=%b r0=%h exp 0 0 0",
                     m0_bus.ready, m1_bus.ready, m0_bus.rdata);
        end
        step();
        sram_bus.ready = 0;
        m0_bus.write_en = 1; m0_bus.address = 32'h800; m0_bus.write_data = 32'h77;
        #1;
        checks++;
        if (sram_bus.write_en !== 1'b0) begin
            failures++;
            $display("FAIL spur_state got we=%b exp=0", sram_bus.write_en);
        end
        step();
        checks++;
        if (sram_bus.write_en !== 1'b1 || sram_bus.write_data !== 32'h77) begin
            failures++;
            $display("FAIL spur_after got we=%b wd=%h exp 1 77",
                     sram_bus.write_en, sram_bus.write_data);
        end
        sram_bus.ready = 1;
        step();
        sram_bus.ready = 0; m0_bus.write_en = 0;
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_read_write_both();
        test_reset_busy();
        test_spurious_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
